// File: rtl/regfile_pkg.sv
// Shared constants and types for the multi-port register file.
// Clear-sweep FSM states and default sizing live here.
package regfile_pkg;

   localparam int DEF_DATA_W = 32;
   localparam int DEF_DEPTH  = 32;
   localparam int DEF_NUM_RD = 2;
   localparam int ZERO_ADDR  = 0;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_CLEAR = 1'b1
   } clr_state_e;

endpackage

// File: rtl/regfile_clear_fsm.sv
// Clear-sweep sequencer: walks every entry once, writing zero.
// Owns busy/clr_done and drives the array's clear write port.
module regfile_clear_fsm
   import regfile_pkg::*;
#(
   parameter int DEPTH  = DEF_DEPTH,
   parameter int ADDR_W = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              i_clr_req,
   output logic              o_busy,
   output logic              o_clr_done,
   output logic              o_clr_we,
   output logic [ADDR_W-1:0] o_clr_addr
);

   localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

   clr_state_e        r_state;
   clr_state_e        w_state_nxt;
   logic [ADDR_W-1:0] r_cnt;
   logic [ADDR_W-1:0] w_cnt_nxt;
   logic              r_done;
   logic              w_done_nxt;

   // State, sweep counter and done pulse registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
         r_cnt   <= '0;
         r_done  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_done  <= w_done_nxt;
      end
   end

   // Next-state: start on request, exit after the last entry is cleared
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_done_nxt  = 1'b0;
      unique case (r_state)
         ST_IDLE: begin
            if (i_clr_req) begin
               w_state_nxt = ST_CLEAR;
               w_cnt_nxt   = '0;
            end
         end
         ST_CLEAR: begin
            w_cnt_nxt = r_cnt + 1'b1;
            if (r_cnt == LAST) begin
               w_state_nxt = ST_IDLE;
               w_cnt_nxt   = '0;
               w_done_nxt  = 1'b1;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   assign o_busy     = (r_state == ST_CLEAR);
   assign o_clr_we   = (r_state == ST_CLEAR);
   assign o_clr_addr = r_cnt;
   assign o_clr_done = r_done;

endmodule

// File: rtl/reg_file_mp.sv
// Multi-read, single-write register file with optional bypass,
// hardwired zero register and a hardware clear sweep.
module reg_file_mp
   import regfile_pkg::*;
#(
   parameter int      DATA_W   = DEF_DATA_W,
   parameter int      DEPTH    = DEF_DEPTH,
   localparam int     ADDR_W   = $clog2(DEPTH),
   parameter int      NUM_RD   = DEF_NUM_RD,
   parameter int      BYPASS   = 1,
   parameter int      ZERO_REG = 1
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
   output logic [NUM_RD*DATA_W-1:0] rd_data,
   input  logic                     wr_en,
   input  logic [ADDR_W-1:0]        wr_addr,
   input  logic [DATA_W-1:0]        wr_data,
   input  logic                     clr_req,
   output logic                     busy,
   output logic                     clr_done
);

   localparam logic [ADDR_W-1:0] ZADDR = ADDR_W'(ZERO_ADDR);

   logic [DATA_W-1:0] r_mem [DEPTH];
   logic              w_busy;
   logic              w_clr_we;
   logic [ADDR_W-1:0] w_clr_addr;
   logic              w_ext_we;
   logic              w_byp_ok;

   regfile_clear_fsm #(
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W)
   ) u_clr (
      .clk        (clk),
      .rst_n      (rst_n),
      .i_clr_req  (clr_req),
      .o_busy     (w_busy),
      .o_clr_done (clr_done),
      .o_clr_we   (w_clr_we),
      .o_clr_addr (w_clr_addr)
   );

   assign busy     = w_busy;
   assign w_byp_ok = wr_en && !w_busy;
   assign w_ext_we = w_byp_ok &&
                     !((ZERO_REG != 0) && (wr_addr == ZADDR));

   // Array update: the sweep owns the port while busy
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < DEPTH; k++) begin
            r_mem[k] <= '0;
         end
      end else if (w_clr_we) begin
         r_mem[w_clr_addr] <= '0;
      end else if (w_ext_we) begin
         r_mem[wr_addr] <= wr_data;
      end
   end

   for (genvar gi = 0; gi < NUM_RD; gi++) begin : g_rd
      logic [ADDR_W-1:0] w_ra;
      logic [DATA_W-1:0] w_rd;

      assign w_ra = rd_addr[gi*ADDR_W +: ADDR_W];

      // Read mux: zero register beats bypass, bypass beats array
      always_comb begin
         w_rd = r_mem[w_ra];
         if ((BYPASS != 0) && w_byp_ok && (wr_addr == w_ra)) begin
            w_rd = wr_data;
         end
         if ((ZERO_REG != 0) && (w_ra == ZADDR)) begin
            w_rd = '0;
         end
      end

      assign rd_data[gi*DATA_W +: DATA_W] = w_rd;
   end

endmodule

// File: tb/tb_reg_file_mp.sv
// Directed bench: vector table for read/write/bypass/zero-reg,
// hand sequences for the clear sweep and mid-sweep reset.
module tb_reg_file_mp;

   localparam int DW = 32;
   localparam int AW = 5;
   localparam int NR = 4;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic [NR*AW-1:0] rd_addr;
   logic [NR*DW-1:0] rd_data;
   logic [NR*DW-1:0] rd_data_b;
   logic             wr_en;
   logic [AW-1:0]    wr_addr;
   logic [DW-1:0]    wr_data;
   logic             clr_req;
   logic             busy;
   logic             busy_b;
   logic             clr_done;
   logic             clr_done_b;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   reg_file_mp #(
      .DATA_W(DW), .DEPTH(32), .NUM_RD(NR),
      .BYPASS(1), .ZERO_REG(1)
   ) u_dut (
      .clk(clk), .rst_n(rst_n),
      .rd_addr(rd_addr), .rd_data(rd_data),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .clr_req(clr_req), .busy(busy), .clr_done(clr_done)
   );

   reg_file_mp #(
      .DATA_W(DW), .DEPTH(32), .NUM_RD(NR),
      .BYPASS(0), .ZERO_REG(0)
   ) u_alt (
      .clk(clk), .rst_n(rst_n),
      .rd_addr(rd_addr), .rd_data(rd_data_b),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .clr_req(clr_req), .busy(busy_b), .clr_done(clr_done_b)
   );

   always @(posedge clk) begin
      if (wr_en === 1'b1) begin
         assert (!$isunknown(wr_addr))
         else $error("wr_addr unknown while wr_en=1");
      end
   end

   typedef struct {
      logic             we;
      logic [AW-1:0]    wa;
      logic [DW-1:0]    wd;
      logic [NR*AW-1:0] ra;
      logic [DW-1:0]    e0, e1, e2, e3;
      logic [DW-1:0]    eb;
   } vec_t;

   vec_t vt [7];

   function automatic logic [DW-1:0] rdp(int i);
      return rd_data[i*DW +: DW];
   endfunction

   function automatic logic [DW-1:0] rdb(int i);
      return rd_data_b[i*DW +: DW];
   endfunction

   task automatic chk(string nm, logic [DW-1:0] act,
                      logic [DW-1:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   function automatic logic [NR*AW-1:0] ra4(int a0, int a1,
                                            int a2, int a3);
      return {AW'(a3), AW'(a2), AW'(a1), AW'(a0)};
   endfunction

   function automatic vec_t mk(logic we, int wa, logic [DW-1:0] wd,
                               logic [NR*AW-1:0] ra,
                               logic [DW-1:0] e0, logic [DW-1:0] e1,
                               logic [DW-1:0] e2, logic [DW-1:0] e3,
                               logic [DW-1:0] eb);
      vec_t v;
      v.we = we; v.wa = AW'(wa); v.wd = wd; v.ra = ra;
      v.e0 = e0; v.e1 = e1; v.e2 = e2; v.e3 = e3; v.eb = eb;
      return v;
   endfunction

   int n;

   initial begin
      vt[0] = mk(1, 3, 32'hDEADBEEF, ra4(3, 3, 5, 0),
                 32'hDEADBEEF, 32'hDEADBEEF, 0, 0, 0);
      vt[1] = mk(0, 0, 0, ra4(3, 5, 0, 31),
                 32'hDEADBEEF, 0, 0, 0, 32'hDEADBEEF);
      vt[2] = mk(1, 0, 32'h12345678, ra4(0, 0, 3, 31),
                 0, 0, 32'hDEADBEEF, 0, 0);
      vt[3] = mk(0, 0, 0, ra4(0, 3, 7, 0),
                 0, 32'hDEADBEEF, 0, 0, 32'h12345678);
      vt[4] = mk(1, 31, 32'h1, ra4(31, 3, 31, 0),
                 1, 32'hDEADBEEF, 1, 0, 0);
      vt[5] = mk(1, 5, 32'hCAFEF00D, ra4(31, 5, 3, 0),
                 1, 32'hCAFEF00D, 32'hDEADBEEF, 0, 1);
      vt[6] = mk(0, 0, 0, ra4(5, 31, 3, 0),
                 32'hCAFEF00D, 1, 32'hDEADBEEF, 0, 32'hCAFEF00D);

      wr_en = 0; wr_addr = 0; wr_data = 0; clr_req = 0;
      rd_addr = ra4(5, 31, 5, 31);
      @(negedge clk);
      #1;
      chk("rst_rd0", rdp(0), 0);
      chk("rst_rd1", rdp(1), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_done", 32'(clr_done), 0);
      @(negedge clk);
      rst_n = 1'b1;
      tick();

      for (int i = 0; i < 7; i++) begin
         wr_en = vt[i].we; wr_addr = vt[i].wa;
         wr_data = vt[i].wd; rd_addr = vt[i].ra;
         #1;
         chk($sformatf("v%0d_p0", i), rdp(0), vt[i].e0);
         chk($sformatf("v%0d_p1", i), rdp(1), vt[i].e1);
         chk($sformatf("v%0d_p2", i), rdp(2), vt[i].e2);
         chk($sformatf("v%0d_p3", i), rdp(3), vt[i].e3);
         chk($sformatf("v%0d_alt", i), rdb(0), vt[i].eb);
         tick();
      end

      // fill every entry with addr*0x11
      for (int a = 0; a < 32; a++) begin
         wr_en = 1; wr_addr = AW'(a); wr_data = 32'(a * 32'h11);
         tick();
      end
      wr_en = 0;
      rd_addr = ra4(7, 10, 31, 0);
      #1;
      chk("fill7", rdp(0), 32'h77);
      chk("fill10", rdp(1), 32'hAA);
      chk("fill31", rdp(2), 32'h20F);
      chk("fill0_zr", rdp(3), 0);
      chk("fill0_alt", rdb(3), 0);

      // clear sweep with a dropped write in the middle
      clr_req = 1;
      #1;
      chk("pre_busy", 32'(busy), 0);
      tick();
      clr_req = 0;
      n = 0;
      for (int c = 0; c < 100; c++) begin
         if (!busy) break;
         n++;
         chk($sformatf("sw_nodone%0d", n), 32'(clr_done), 0);
         if (n == 3) begin
            wr_en = 1; wr_addr = 7; wr_data = 32'hAA;
            rd_addr = ra4(7, 1, 2, 0);
            #1;
            chk("clr_nobyp", rdp(0), 32'h77);
            chk("clr_part1", rdp(1), 0);
            chk("clr_part2", rdp(2), 32'h22);
         end
         tick();
         wr_en = 0;
      end
      chk("sweep_len", n, 32);
      chk("sweep_done", 32'(clr_done), 1);
      chk("sweep_busy_b", 32'(busy_b), 0);
      tick();
      chk("done_pulse", 32'(clr_done), 0);
      for (int a = 0; a < 32; a++) begin
         rd_addr = ra4(a, a, a, a);
         #1;
         chk($sformatf("clr_e%0d", a), rdb(1), 0);
      end
      rd_addr = ra4(7, 7, 7, 7);
      #1;
      chk("clr_e7_dut", rdp(0), 0);

      // request held across completion restarts the sweep
      clr_req = 1;
      tick();
      n = 0;
      for (int c = 0; c < 100; c++) begin
         if (!busy) break;
         n++;
         tick();
      end
      chk("hold_len", n, 32);
      chk("hold_done", 32'(clr_done), 1);
      tick();
      clr_req = 0;
      chk("hold_restart", 32'(busy), 1);
      n = 0;
      for (int c = 0; c < 100; c++) begin
         if (!busy) break;
         n++;
         tick();
      end
      chk("hold_len2", n, 32);

      // reset in the middle of a sweep
      wr_en = 1; wr_addr = 9; wr_data = 32'h99; tick();
      wr_addr = 20; wr_data = 32'h2020; tick();
      wr_en = 0;
      clr_req = 1;
      tick();
      clr_req = 0;
      for (int c = 0; c < 9; c++) tick();
      chk("mid_busy", 32'(busy), 1);
      rd_addr = ra4(20, 9, 20, 9);
      #1;
      chk("mid_pre20", rdp(0), 32'h2020);
      #1;
      rst_n = 0;
      #1;
      chk("mid_rst_busy", 32'(busy), 0);
      chk("mid_rst_done", 32'(clr_done), 0);
      chk("mid_rst_20", rdp(0), 0);
      chk("mid_rst_9", rdp(1), 0);
      @(negedge clk);
      rst_n = 1;
      n = 0;
      for (int c = 0; c < 40; c++) begin
         if (clr_done) n++;
         tick();
      end
      chk("mid_nodone", n, 0);

      // four ports, four distinct addresses
      for (int a = 1; a < 5; a++) begin
         wr_en = 1; wr_addr = AW'(a); wr_data = 32'h100 * a + 32'h5;
         tick();
      end
      wr_en = 0;
      rd_addr = ra4(4, 3, 2, 1);
      #1;
      chk("p4_0", rdp(0), 32'h405);
      chk("p4_1", rdp(1), 32'h305);
      chk("p4_2", rdp(2), 32'h205);
      chk("p4_3", rdp(3), 32'h105);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
